ar_br_cr_arbiter: RTL

AR_BR_CR_ARBITER -- requirements
Module: ar_br_cr_arbiter

---
 rtl/ar_br_cr_pkg.sv | 18 +
 rtl/ar_br_cr_rr_arb.sv | 43 ++++
 rtl/ar_br_cr_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/ar_br_cr_pkg.sv
// Shared types and constants for the AR/BR/CR two-requester arbiter.
// The AR_BR_CR_ARB_RR_EN macro switches arbitration to round-robin.
package ar_br_cr_pkg;

    localparam int DW_DEF = 16;
    localparam int NREQ   = 2;
    localparam int REQ0   = 0;
    localparam int REQ1   = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EVAL,
        S_CAPT,
        S_DONE
    } state_t;

endpackage

// File: rtl/ar_br_cr_rr_arb.sv
// Two-way arbiter. Round-robin when AR_BR_CR_ARB_RR_EN is defined,
// otherwise fixed priority with requester 0 winning a tie.
module ar_br_cr_rr_arb
    import ar_br_cr_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    output logic [NREQ-1:0] win
);

`ifdef AR_BR_CR_ARB_RR_EN
    logic fav;
    logic win1_q;

    always_comb begin
        win = req;
        if (&req) win = fav ? 2'b10 : 2'b01;
    end

    // win1_q holds the winner of the arbitration cycle that led into LOAD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fav    <= 1'b0;
            win1_q <= 1'b0;
        end else begin
            win1_q <= win[REQ1];
            if (adv) fav <= ~win1_q;
        end
    end
`else
    logic unused_fp;

    assign unused_fp = ^{clk, rst, adv};

    always_comb begin
        win = req;
        if (req[REQ0]) win = 2'b01;
    end
`endif

endmodule

// File: rtl/ar_br_cr_arbiter.sv
// Sequences one shared AR/BR/CR datapath between two requesters.
// Define AR_BR_CR_ARB_RR_EN for round-robin instead of fixed priority.
module ar_br_cr_arbiter
    import ar_br_cr_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [DW-1:0] a0_data,
    input  logic [DW-1:0] b0_data,
    input  logic [DW-1:0] a1_data,
    input  logic [DW-1:0] b1_data,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic          load_AR_BR,
    output logic          div_AR_T_CR,
    output logic          mul_BR_T_CR,
    output logic          clr_CR,
    output logic [DW-1:0] AR_data,
    output logic [DW-1:0] BR_data,
    input  logic          AR_neg,
    input  logic          AR_pos,
    input  logic          AR_zero,
    input  logic [DW-1:0] CR_data
);

    state_t          state;
    logic [NREQ-1:0] win;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] done_q;
    logic            busy_q;
    logic            load_q;
    logic [DW-1:0]   rsp_q;
    logic            eval;
    logic            onehot;

    ar_br_cr_rr_arb u_arb (
        .clk (clk),
        .rst (reset),
        .req ({req1, req0}),
        .adv (state == S_LOAD),
        .win (win)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            gnt_q  <= '0;
            done_q <= '0;
            busy_q <= 1'b0;
            load_q <= 1'b0;
            rsp_q  <= '0;
        end else begin
            done_q <= '0;
            load_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (|win) begin
                        state  <= S_LOAD;
                        gnt_q  <= win;
                        busy_q <= 1'b1;
                        load_q <= 1'b1;
                    end
                end
                S_LOAD: state <= S_EVAL;
                S_EVAL: state <= S_CAPT;
                S_CAPT: begin
                    state  <= S_DONE;
                    rsp_q  <= CR_data;
                    done_q <= gnt_q;
                end
                S_DONE: begin
                    if (|win) begin
                        state  <= S_LOAD;
                        gnt_q  <= win;
                        load_q <= 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Flags become valid only once AR is loaded, so the strobe is decoded live
    assign eval   = (state == S_EVAL);
    assign onehot = $onehot({AR_neg, AR_pos, AR_zero});

    assign div_AR_T_CR = eval & onehot & AR_neg;
    assign mul_BR_T_CR = eval & onehot & AR_pos;
    assign clr_CR      = eval & (~onehot | AR_zero);

    assign gnt0       = gnt_q[REQ0];
    assign gnt1       = gnt_q[REQ1];
    assign done0      = done_q[REQ0];
    assign done1      = done_q[REQ1];
    assign busy       = busy_q;
    assign load_AR_BR = load_q;
    assign rsp_data   = rsp_q;

    assign AR_data = gnt_q[REQ0] ? a0_data :
                     gnt_q[REQ1] ? a1_data : '0;
    assign BR_data = gnt_q[REQ0] ? b0_data :
                     gnt_q[REQ1] ? b1_data : '0;

endmodule
